// File: rtl/alu_exec_if.sv
// -----------------------------------------------------------------------------
// alu_exec_if
// Groups the handshake and data signals of the ALU execute stage.
//
//   Upstream side (shifter -> execute):
//     in_valid, in_ready, opcode, set_flags, cond_pass,
//     rn_data, op2_data, shifter_carry, rd_addr_in
//   Downstream side (execute -> writeback):
//     out_valid, out_ready, result, rd_addr_out, write_en
//   Architectural state:
//     flags (NZCV, bit 3 = N, bit 0 = V)
//
// Modports:
//   slave  - the execute stage itself
//   master - whatever drives the stage (upstream + writeback, or a bench)
// -----------------------------------------------------------------------------
interface alu_exec_if #(
   parameter int REG_ADDR_W = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            opcode;
   logic                  set_flags;
   logic                  cond_pass;
   logic [31:0]           rn_data;
   logic [31:0]           op2_data;
   logic                  shifter_carry;
   logic [REG_ADDR_W-1:0] rd_addr_in;

   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           result;
   logic [REG_ADDR_W-1:0] rd_addr_out;
   logic                  write_en;
   logic [3:0]            flags;

   modport slave (
      input  in_valid, opcode, set_flags, cond_pass, rn_data, op2_data,
             shifter_carry, rd_addr_in, out_ready,
      output in_ready, out_valid, result, rd_addr_out, write_en, flags
   );

   modport master (
      output in_valid, opcode, set_flags, cond_pass, rn_data, op2_data,
             shifter_carry, rd_addr_in, out_ready,
      input  in_ready, out_valid, result, rd_addr_out, write_en, flags
   );
endinterface

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Execute stage sitting directly after the operand-2 shifter. Performs the 16
// ARM data-processing operations on Rn and shifted operand 2, registers the
// result and destination tag into a single valid/ready pipeline slot toward
// writeback, and owns the architectural NZCV flag register.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous, active-high reset
//   bus (slave)  - alu_exec_if: upstream handshake/operands, downstream
//                  handshake/result/tag/write enable, NZCV flags
//   stall_count  - (only with EXEC_STALL_CNT_EN) saturating 16-bit count of
//                  cycles where the slot is full and writeback is not ready
//
// Optional feature macro: EXEC_STALL_CNT_EN
//
// Parameters:
//   REG_ADDR_W   - width of the destination register tag
//   FLAGS_RESET  - NZCV value loaded on reset
// -----------------------------------------------------------------------------
module alu_exec_stage #(
   parameter int         REG_ADDR_W  = 4,
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   alu_exec_if.slave   bus
`ifdef EXEC_STALL_CNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   typedef enum logic [3:0] {
      OP_AND = 4'h0,
      OP_EOR = 4'h1,
      OP_SUB = 4'h2,
      OP_RSB = 4'h3,
      OP_ADD = 4'h4,
      OP_ADC = 4'h5,
      OP_SBC = 4'h6,
      OP_RSC = 4'h7,
      OP_TST = 4'h8,
      OP_TEQ = 4'h9,
      OP_CMP = 4'hA,
      OP_CMN = 4'hB,
      OP_ORR = 4'hC,
      OP_MOV = 4'hD,
      OP_BIC = 4'hE,
      OP_MVN = 4'hF
   } alu_op_e;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      if (val == 16'hFFFF) begin
         return val;
      end
      return val + 16'd1;
   endfunction

   // Pack NZCV from a result and the computed carry/overflow.
   function automatic logic [3:0] pack_nzcv(input logic [31:0] res,
                                            input logic        c,
                                            input logic        v);
      return {res[31], (res == 32'd0), c, v};
   endfunction

   // Slot and architectural state
   logic                  r_out_valid_p1;
   logic [31:0]           r_result_p1;
   logic [REG_ADDR_W-1:0] r_rd_addr_p1;
   logic                  r_write_en_p1;
   logic [3:0]            r_flags;

   // Stage-0 combinational datapath
   alu_op_e               w_op_p0;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_drain;
   logic                  w_cin_p0;
   logic                  w_is_arith_p0;
   logic                  w_is_cmp_p0;
   logic [31:0]           w_add_a_p0;
   logic [31:0]           w_add_b_p0;
   logic                  w_add_ci_p0;
   logic [32:0]           w_sum_p0;
   logic                  w_ovf_p0;
   logic [31:0]           w_logic_p0;
   logic [31:0]           w_res_p0;
   logic                  w_c_p0;
   logic                  w_v_p0;
   logic [3:0]            w_flags_p0;
   logic                  w_we_p0;
   logic                  w_flag_upd_p0;

   assign w_op_p0    = alu_op_e'(bus.opcode);
   assign w_in_ready = !r_out_valid_p1 || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_drain    = r_out_valid_p1 && bus.out_ready;

   // Carry-in is the architectural C as it stands at accept; a flag update
   // from the previous instruction is already registered by then.
   assign w_cin_p0   = r_flags[1];

   // TST/TEQ/CMP/CMN occupy opcodes 8..B.
   assign w_is_cmp_p0 = (bus.opcode[3:2] == 2'b10);

   // Every arithmetic op is folded onto a single adder: a + b + ci.
   // Subtracts invert the subtrahend and feed 1 (or Cin) as carry-in, which
   // makes bit 32 of the sum the ARM "NOT borrow" carry.
   always_comb begin
      w_add_a_p0    = bus.rn_data;
      w_add_b_p0    = bus.op2_data;
      w_add_ci_p0   = 1'b0;
      w_is_arith_p0 = 1'b1;
      unique case (w_op_p0)
         OP_SUB, OP_CMP: begin
            w_add_b_p0  = ~bus.op2_data;
            w_add_ci_p0 = 1'b1;
         end
         OP_RSB: begin
            w_add_a_p0  = bus.op2_data;
            w_add_b_p0  = ~bus.rn_data;
            w_add_ci_p0 = 1'b1;
         end
         OP_ADD, OP_CMN: begin
            w_add_ci_p0 = 1'b0;
         end
         OP_ADC: begin
            w_add_ci_p0 = w_cin_p0;
         end
         OP_SBC: begin
            w_add_b_p0  = ~bus.op2_data;
            w_add_ci_p0 = w_cin_p0;
         end
         OP_RSC: begin
            w_add_a_p0  = bus.op2_data;
            w_add_b_p0  = ~bus.rn_data;
            w_add_ci_p0 = w_cin_p0;
         end
         default: begin
            w_is_arith_p0 = 1'b0;
         end
      endcase
   end

   assign w_sum_p0 = {1'b0, w_add_a_p0} + {1'b0, w_add_b_p0} + {32'd0, w_add_ci_p0};

   // Signed overflow: both adder inputs share a sign that the sum lacks.
   assign w_ovf_p0 = (w_add_a_p0[31] == w_add_b_p0[31]) &&
                     (w_sum_p0[31] != w_add_a_p0[31]);

   always_comb begin
      w_logic_p0 = 32'd0;
      unique case (w_op_p0)
         OP_AND, OP_TST: w_logic_p0 = bus.rn_data & bus.op2_data;
         OP_EOR, OP_TEQ: w_logic_p0 = bus.rn_data ^ bus.op2_data;
         OP_ORR:         w_logic_p0 = bus.rn_data | bus.op2_data;
         OP_MOV:         w_logic_p0 = bus.op2_data;
         OP_BIC:         w_logic_p0 = bus.rn_data & ~bus.op2_data;
         OP_MVN:         w_logic_p0 = ~bus.op2_data;
         default:        w_logic_p0 = 32'd0;
      endcase
   end

   // Logical ops take C from the shifter and leave V alone.
   assign w_res_p0   = w_is_arith_p0 ? w_sum_p0[31:0] : w_logic_p0;
   assign w_c_p0     = w_is_arith_p0 ? w_sum_p0[32]   : bus.shifter_carry;
   assign w_v_p0     = w_is_arith_p0 ? w_ovf_p0       : r_flags[0];
   assign w_flags_p0 = pack_nzcv(w_res_p0, w_c_p0, w_v_p0);

   assign w_we_p0       = bus.cond_pass && !w_is_cmp_p0;
   assign w_flag_upd_p0 = w_accept && bus.cond_pass && (bus.set_flags || w_is_cmp_p0);

   // ---- stage boundary p0 -> p1: result slot and NZCV register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid_p1 <= 1'b0;
         r_result_p1    <= 32'd0;
         r_rd_addr_p1   <= '0;
         r_write_en_p1  <= 1'b0;
         r_flags        <= FLAGS_RESET;
      end else begin
         if (w_accept) begin
            // Covers both a fresh fill and a same-cycle drain+replace.
            r_out_valid_p1 <= 1'b1;
            r_result_p1    <= w_res_p0;
            r_rd_addr_p1   <= bus.rd_addr_in;
            r_write_en_p1  <= w_we_p0;
         end else if (w_drain) begin
            r_out_valid_p1 <= 1'b0;
         end
         if (w_flag_upd_p0) begin
            r_flags <= w_flags_p0;
         end
      end
   end

`ifdef EXEC_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= 16'd0;
      end else if (r_out_valid_p1 && !bus.out_ready) begin
         r_stall_cnt <= sat_inc16(r_stall_cnt);
      end
   end

   assign stall_count = r_stall_cnt;
`endif

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_out_valid_p1;
   assign bus.result      = r_result_p1;
   assign bus.rd_addr_out = r_rd_addr_p1;
   assign bus.write_en    = r_write_en_p1;
   assign bus.flags       = r_flags;

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model that evaluates each opcode with wide integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

   localparam longint MAX_S = 64'sh0000_0000_7FFF_FFFF;
   localparam longint MIN_S = -64'sh0000_0000_8000_0000;
   localparam longint MAX_U = 64'sh0000_0000_FFFF_FFFF;

   logic clk;
   logic reset;

   alu_exec_if #(.REG_ADDR_W(4)) bus ();

`ifdef EXEC_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   alu_exec_stage #(
      .REG_ADDR_W (4),
      .FLAGS_RESET(4'b0000)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
`ifdef EXEC_STALL_CNT_EN
      ,
      .stall_count(stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state
   logic        m_valid;
   logic [31:0] m_res;
   logic [3:0]  m_rd;
   logic        m_we;
   logic [3:0]  m_flags;
   int          m_stall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Reference ALU: each operation evaluated with 64-bit integers, carry from
   // unsigned range, overflow from signed range.
   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin,
                                   input logic sc, input logic [3:0] fl,
                                   output logic [31:0] r, output logic [3:0] nf);
      longint ua, ub, sa, sb, u, s, ci, nb;
      logic   c, v;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ci = cin ? 64'sd1 : 64'sd0;
      nb = cin ? 64'sd0 : 64'sd1;
      u  = 0;
      s  = 0;
      c  = sc;
      v  = fl[0];
      r  = 32'd0;
      case (op)
         4'h0, 4'h8: r = a & b;
         4'h1, 4'h9: r = a ^ b;
         4'hC:       r = a | b;
         4'hD:       r = b;
         4'hE:       r = a & ~b;
         4'hF:       r = ~b;
         default: begin
            case (op)
               4'h2, 4'hA: begin u = ua - ub;      s = sa - sb;      end
               4'h3:       begin u = ub - ua;      s = sb - sa;      end
               4'h4, 4'hB: begin u = ua + ub;      s = sa + sb;      end
               4'h5:       begin u = ua + ub + ci; s = sa + sb + ci; end
               4'h6:       begin u = ua - ub - nb; s = sa - sb - nb; end
               4'h7:       begin u = ub - ua - nb; s = sb - sa - nb; end
               default:    ;
            endcase
            r = u[31:0];
            if (op == 4'h4 || op == 4'h5 || op == 4'hB) c = (u > MAX_U);
            else                                        c = (u >= 0);
            v = (s > MAX_S) || (s < MIN_S);
         end
      endcase
      nf = {r[31], (r == 32'd0), c, v};
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_res   = 32'd0;
      m_rd    = 4'd0;
      m_we    = 1'b0;
      m_flags = 4'b0000;
      m_stall = 0;
   endtask

   task automatic check_outputs();
      check("out_valid",   32'(bus.out_valid),   32'(m_valid));
      check("result",      bus.result,           m_res);
      check("rd_addr_out", 32'(bus.rd_addr_out), 32'(m_rd));
      check("write_en",    32'(bus.write_en),    32'(m_we));
      check("flags",       32'(bus.flags),       32'(m_flags));
`ifdef EXEC_STALL_CNT_EN
      check("stall_count", 32'(stall_count),     32'(m_stall));
`endif
   endtask

   // One clock: settle inputs, predict the edge, advance, compare.
   task automatic tick();
      logic        acc, stall_pre, cmp;
      logic [31:0] r;
      logic [3:0]  nf;
      #2;
      check("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      acc       = bus.in_valid && (!m_valid || bus.out_ready);
      stall_pre = m_valid && !bus.out_ready;
      cmp       = (bus.opcode >= 4'h8) && (bus.opcode <= 4'hB);
      if (acc) begin
         ref_alu(bus.opcode, bus.rn_data, bus.op2_data, m_flags[1],
                 bus.shifter_carry, m_flags, r, nf);
         m_valid = 1'b1;
         m_res   = r;
         m_rd    = bus.rd_addr_in;
         m_we    = bus.cond_pass && !cmp;
         if (bus.cond_pass && (bus.set_flags || cmp)) m_flags = nf;
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
      end
      if (stall_pre && m_stall < 65535) m_stall++;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic cp, input logic sc, input logic [3:0] rd);
      bus.in_valid      = 1'b1;
      bus.opcode        = op;
      bus.rn_data       = a;
      bus.op2_data      = b;
      bus.set_flags     = s;
      bus.cond_pass     = cp;
      bus.shifter_carry = sc;
      bus.rd_addr_in    = rd;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic cp, input logic sc, input logic [3:0] rd);
      drive(op, a, b, s, cp, sc, rd);
      tick();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [4];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'hFFFF_FFFF;
      specials[2] = 32'h8000_0000;
      specials[3] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      reset = 1'b1;
      bus.out_ready = 1'b1;
      drive(4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      bus.in_valid = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_outputs();
      reset = 1'b0;

      // Reset mid-stream with a full slot and non-zero flags
      bus.out_ready = 1'b0;
      issue(4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 4'd5);
      check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_async_valid", 32'(bus.out_valid), 32'd0);
      check("rst_async_we",    32'(bus.write_en),  32'd0);
      check("rst_async_flags", 32'(bus.flags),     32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.out_ready = 1'b1;

      // ADDS carry/zero
      issue(4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 4'd3);
      check("adds_result", bus.result,           32'd0);
      check("adds_we",     32'(bus.write_en),    32'd1);
      check("adds_rd",     32'(bus.rd_addr_out), 32'd3);
      check("adds_flags",  32'(bus.flags),       32'b0110);

      // SUBS overflow, then CMP
      issue(4'h2, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 4'd1);
      check("subs_result", bus.result,     32'h7FFF_FFFF);
      check("subs_flags",  32'(bus.flags), 32'b0011);
      issue(4'hA, 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 4'd2);
      check("cmp_we",     32'(bus.write_en), 32'd0);
      check("cmp_result", bus.result,        32'hFFFF_FFFE);
      check("cmp_flags",  32'(bus.flags),    32'b1000);

      // ADC chain, back to back
      issue(4'h4, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 1'b0, 4'd4);
      check("adc_pre_c", 32'(bus.flags[1]), 32'd1);
      issue(4'h5, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 4'd4);
      check("adc_result", bus.result, 32'd3);

      // Logical carry: first force V=1, then MOVS keeps it
      issue(4'h2, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 4'd1);
      issue(4'hD, 32'h1234_5678, 32'd0, 1'b1, 1'b1, 1'b1, 4'd6);
      check("movs_flags", 32'(bus.flags), 32'b0111);
      issue(4'hC, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 1'b0, 1'b0, 4'd7);
      check("orr_nc_we",    32'(bus.write_en), 32'd0);
      check("orr_nc_flags", 32'(bus.flags),    32'b0111);
      check("orr_nc_res",   bus.result,        32'hF0F0_0F0F);

      // Backpressure: drain first, then fill and hold for 3 cycles
      idle();
      bus.out_ready = 1'b0;
      issue(4'hD, 32'd0, 32'd111, 1'b0, 1'b1, 1'b0, 4'd8);
      drive(4'hD, 32'd0, 32'd222, 1'b0, 1'b1, 1'b0, 4'd9);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_ready_low", 32'(bus.in_ready), 32'd0);
         check("bp_hold_res",  bus.result,        32'd111);
      end
`ifdef EXEC_STALL_CNT_EN
      check("bp_stall_cnt", 32'(stall_count), 32'd3);
`endif
      bus.out_ready = 1'b1;
      tick();
      check("bp_replace_valid", 32'(bus.out_valid), 32'd1);
      check("bp_replace_res",   bus.result,         32'd222);
      issue(4'hD, 32'd0, 32'd333, 1'b0, 1'b1, 1'b0, 4'd10);
      check("bp_next_res", bus.result, 32'd333);
      idle();
      check("bp_drained", 32'(bus.out_valid), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
               1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the operand-2 shifter.
- Consumes Rn and shifted operand 2 and performs the 16 ARM data-processing operations.
- Registers the result and the destination tag into a single pipeline slot with a valid/ready handshake toward writeback.
- Holds the architectural NZCV flag register.

Parameters:
- REG_ADDR_W, 4: width of the destination register tag.
- FLAGS_RESET, 4'b0000: NZCV value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- opcode  input  4  ARM data-processing opcode [24:21].
- set_flags  input  1  S bit.
- cond_pass  input  1  condition check passed.
- rn_data  input  32  first operand.
- op2_data  input  32  shifted operand 2 (shifter output).
- shifter_carry  input  1  carry-out from the shifter.
- rd_addr_in  input  REG_ADDR_W  destination tag.
- out_valid  output  1  result slot holds an instruction.
- out_ready  input  1  downstream accepts this cycle.
- result  output  32  registered ALU result.
- rd_addr_out  output  REG_ADDR_W  registered destination tag.
- write_en  output  1  registered register-file write enable.
- flags  output  4  architectural NZCV; bit 3 = N, bit 0 = V.

Behaviour:
- Reset (asynchronous):
  - out_valid=0, result=0, rd_addr_out=0, write_en=0.
  - flags=FLAGS_RESET.
  - Reset mid-operation discards the slot contents.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Outputs are held stable while out_valid && !out_ready.
  - Drain occurs when out_valid && out_ready with no accept; out_valid then goes to 0 next cycle.
  - Simultaneous drain and accept replaces the slot in one cycle; out_valid stays 1, giving full throughput.
- Latency: 1 cycle from accept to out_valid.
- Operations (A=rn_data, B=op2_data, Cin=flags[1] sampled at accept):
  - 0 AND: A&B
  - 1 EOR: A^B
  - 2 SUB: A-B
  - 3 RSB: B-A
  - 4 ADD: A+B
  - 5 ADC: A+B+Cin
  - 6 SBC: A-B-!Cin
  - 7 RSC: B-A-!Cin
  - 8 TST, 9 TEQ, A CMP, B CMN: as AND, EOR, SUB, ADD respectively.
  - C ORR: A|B
  - D MOV: B
  - E BIC: A&~B
  - F MVN: ~B
- Arithmetic uses a 33-bit sum.
  - Subtraction is A + ~B + carry-in (1 for SUB/CMP/RSB, Cin for SBC/RSC).
  - C = bit 32 of that sum; for subtraction, C = NOT borrow.
  - V = signed overflow of the 32-bit sum.
- Logical ops (AND EOR TST TEQ ORR MOV BIC MVN):
  - C = shifter_carry.
  - V unchanged.
- N = result[31]. Z = (result==0).
- write_en = cond_pass && opcode not in {8,9,A,B}.
  - The result register still loads the computed value even when write_en=0.
- Flags update on accept only, when cond_pass && (set_flags || opcode in {8..B}).
  - The compare opcodes always set flags.
  - The new value is visible the cycle after accept, so back-to-back ADC sees the preceding instruction's carry.
- cond_pass=0: instruction still flows through as a slot with write_en=0; flags untouched.
- No accept and no drain: all state holds.

Optional Feature:
- Macro EXEC_STALL_CNT_EN.
- Defined:
  - Adds output port stall_count, 16 bits.
  - Increments each cycle where out_valid && !out_ready.
  - Saturates at 16'hFFFF (no wrap).
  - Reset to 0 by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset flags: assert reset mid-stream with out_valid=1 -> out_valid=0, write_en=0, flags=0000 immediately, without waiting for a clock edge.
- ADDS carry/zero:
  - Stimulus: A=FFFFFFFF, B=00000001, opcode 4, S=1, rd=3.
  - Next cycle: result=0, write_en=1, rd_addr_out=3, flags N=0 Z=1 C=1 V=0.
- SUBS overflow then CMP:
  - SUBS A=80000000, B=1 -> result=7FFFFFFF, flags 0011 (C=1, V=1).
  - Then CMP A=5, B=7 -> write_en=0, result=FFFFFFFE, flags 1000.
- ADC chain:
  - ADDS A=FFFFFFFF, B=2 (sets C=1), then ADC A=1, B=1 on the next cycle.
  - Second result=3.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 throughout, outputs stable, no instruction lost.
  - Release -> one drain-and-accept per cycle.
  - With EXEC_STALL_CNT_EN: stall_count=3.
- Logical carry and cond fail:
  - MOVS B=0, shifter_carry=1 -> flags Z=1 C=1, V keeps its prior value.
  - ORR with cond_pass=0 -> write_en=0, flags unchanged.
